sdr_tx_framer: RTL

- Transmit-side SDR data framer for the I3C engine.
- Accepts bytes from the TX FIFO over a valid/ready handshake and serialises each as one SDR frame: 8 data bits MSB first, then the T-bit.
- Steps one bit per SCL-generator tick, counts frames against a programmed total, and flags the last frame and completion.
- Sits between the TX FIFO and the SDA output mux.

---
 rtl/sdr_tx_framer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sdr_tx_framer.sv
// I3C SDR transmit framer: takes bytes from the TX FIFO and shifts each out MSB
// first followed by a T-bit, one bit per SCL-generator tick.
module sdr_tx_framer #(
    parameter int T_MODE = 0
) (
    input  logic       i_sdrtx_clk,
    input  logic       i_sdrtx_rst,
    input  logic       i_sdrtx_en,
    input  logic [7:0] i_sdrtx_no_frms,
    input  logic       i_sdrtx_bit_tick,
    input  logic [7:0] i_sdrtx_data,
    input  logic       i_sdrtx_data_valid,
    output logic       o_sdrtx_data_ready,
    output logic       o_sdrtx_sda,
    output logic       o_sdrtx_sda_oe,
    output logic [7:0] o_sdrtx_frm_cnt,
    output logic       o_sdrtx_last_frame,
    output logic       o_sdrtx_done,
    output logic       o_sdrtx_underrun
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHIFT, S_TBIT, S_DONE} state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] fetched_q, fetched_d;
    logic [7:0] no_frms_q, no_frms_d;
    logic [7:0] frm_cnt_q, frm_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] frame_q, frame_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       underrun_q, underrun_d;
    logic       en_prev_q;
    logic       sda_q, sda_d;
    logic       oe_q, oe_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
    logic [7:0] frm_inc;
    logic       accept;

    function automatic logic tbit_f(input logic [7:0] frame, input logic [7:0] cnt,
                                    input logic [7:0] total);
        if (T_MODE == 0) return ~^frame;
        return (cnt != total - 8'd1);
    endfunction

    assign o_sdrtx_data_ready = (state_q == S_WAIT || state_q == S_SHIFT || state_q == S_TBIT)
                                && !hold_full_q && (fetched_q < no_frms_q);
    assign accept = i_sdrtx_data_valid && o_sdrtx_data_ready;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        fetched_d   = fetched_q;
        no_frms_d   = no_frms_q;
        frm_cnt_d   = frm_cnt_q;
        shreg_d     = shreg_q;
        frame_d     = frame_q;
        bit_idx_d   = bit_idx_q;
        underrun_d  = underrun_q;
        frm_inc     = frm_cnt_q + 8'd1;

        if (accept) begin
            hold_d      = i_sdrtx_data;
            hold_full_d = 1'b1;
            fetched_d   = fetched_q + 8'd1;
        end

        // State transitions below override the handshake write where the held
        // byte is consumed or discarded (abort, underrun, done).
        unique case (state_q)
            S_IDLE: begin
                if (i_sdrtx_en && !en_prev_q) begin
                    no_frms_d   = i_sdrtx_no_frms;
                    frm_cnt_d   = 8'd0;
                    fetched_d   = 8'd0;
                    underrun_d  = 1'b0;
                    hold_full_d = 1'b0;
                    state_d     = (i_sdrtx_no_frms == 8'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_sdrtx_en) begin
                    state_d     = S_IDLE;
                    hold_full_d = 1'b0;
                end else if (hold_full_q) begin
                    shreg_d     = hold_q;
                    frame_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_idx_d   = 3'd0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!i_sdrtx_en) begin
                    state_d     = S_IDLE;
                    hold_full_d = 1'b0;
                end else if (i_sdrtx_bit_tick) begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_TBIT;
                end
            end
            S_TBIT: begin
                if (!i_sdrtx_en) begin
                    state_d     = S_IDLE;
                    hold_full_d = 1'b0;
                end else if (i_sdrtx_bit_tick) begin
                    frm_cnt_d = frm_inc;
                    if (frm_inc == no_frms_q) begin
                        state_d     = S_DONE;
                        hold_full_d = 1'b0;
                    end else if (hold_full_q) begin
                        shreg_d     = hold_q;
                        frame_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_idx_d   = 3'd0;
                        state_d     = S_SHIFT;
                    end else begin
                        underrun_d  = 1'b1;
                        hold_full_d = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                hold_full_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        oe_d   = (state_d == S_SHIFT) || (state_d == S_TBIT);
        sda_d  = 1'b1;
        if (state_d == S_SHIFT) sda_d = shreg_d[7];
        else if (state_d == S_TBIT) sda_d = tbit_f(frame_d, frm_cnt_d, no_frms_d);
        last_d = oe_d && (frm_cnt_d == no_frms_d - 8'd1);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_sdrtx_clk) begin
        if (i_sdrtx_rst) begin
            state_q     <= S_IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            fetched_q   <= 8'd0;
            no_frms_q   <= 8'd0;
            frm_cnt_q   <= 8'd0;
            shreg_q     <= 8'd0;
            frame_q     <= 8'd0;
            bit_idx_q   <= 3'd0;
            underrun_q  <= 1'b0;
            // Treat en as already high so a level held through reset cannot start a transfer.
            en_prev_q   <= 1'b1;
            sda_q       <= 1'b1;
            oe_q        <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            fetched_q   <= fetched_d;
            no_frms_q   <= no_frms_d;
            frm_cnt_q   <= frm_cnt_d;
            shreg_q     <= shreg_d;
            frame_q     <= frame_d;
            bit_idx_q   <= bit_idx_d;
            underrun_q  <= underrun_d;
            en_prev_q   <= i_sdrtx_en;
            sda_q       <= sda_d;
            oe_q        <= oe_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign o_sdrtx_sda        = sda_q;
    assign o_sdrtx_sda_oe     = oe_q;
    assign o_sdrtx_frm_cnt    = frm_cnt_q;
    assign o_sdrtx_last_frame = last_q;
    assign o_sdrtx_done       = done_q;
    assign o_sdrtx_underrun   = underrun_q;

endmodule
